honzales_stream: RTL
====================

// Module: honzales_stream
// PURPOSE
// - Parametrised, pipelined successor to the single-cycle +1 incrementer: streams WIDTH-bit words through a 2-stage
//   valid/ready pipeline, applying a runtime-selectable op (wrap add, saturating add, accumulate, wrap subtract).
// - Sits between the Caravel user-IO/logic-analyser side and the testbench wrapper; carries full backpressure.
// PARAMETERS
// - WIDTH       20   data/result width in bits
// - STEP_W      8    width of runtime step operand (STEP_W <= WIDTH), zero-extended to WIDTH
// - RESET_STEP  1    step value loaded into the step register at reset
// PORTS
// - clock          in   1        single clock, all state on rising edge
// - reset          in   1        synchronous, active-low (0 = reset), sampled on rising clock edge
// - io_in_valid    in   1        input word present
// - io_in_ready    out  1        block accepts input this cycle
// - io_in_data     in   WIDTH    operand
// - io_mode        in   2        op, captured with each accepted word: 00 ADD, 01 SATADD, 10 ACC, 11 SUB
// - io_step_we     in   1        load io_step into step register
// - io_step        in   STEP_W   new step value
// - io_out_valid   out  1        result present
// - io_out_ready   in   1        downstream accepts result
// - io_out_data    out  WIDTH    result
// - io_out_ovf     out  1        result wrapped/saturated/borrowed
// BEHAVIOUR
// - Reset (reset==0 at edge): s1/s2 valid=0, acc=0, step=RESET_STEP; outputs io_out_valid=0, io_out_data=0,
//   io_out_ovf=0, io_in_ready=1 from the cycle after reset deasserts. Reset mid-operation discards all in-flight words.
// - Handshake: transfer on valid&&ready. io_out_valid/data/ovf held stable while io_out_valid&&!io_out_ready.
//   io_in_ready = !s1_valid || s1_moves; s1_moves = !s2_valid || io_out_ready (no combinational path in_valid->in_ready).
// - Stage 1 registers {data, mode, step}; stage 2 registers computed result. Latency: word accepted at edge N
//   appears on io_out at N+2 with no backpressure. Throughput 1 word/cycle; two words buffered max.
// - Step: sampled into s1 with the accepted word; io_step_we takes effect for words accepted on the NEXT edge;
//   simultaneous io_step_we and accept uses the OLD step.
// - Arithmetic (all on WIDTH bits, step zero-extended):
//   ADD    r = (d+step) mod 2^WIDTH; ovf = carry out.
//   SATADD r = min(d+step, 2^WIDTH-1); ovf = 1 iff clamped.
//   SUB    r = (d-step) mod 2^WIDTH; ovf = borrow.
//   ACC    r = (acc+d) mod 2^WIDTH, step ignored; ovf = carry; acc <= r on the s1->s2 transfer only.
// - acc is unaffected by non-ACC words; only reset clears it.
// - Stall: when s2 full and io_out_ready=0, s1 holds, acc holds; no word dropped or duplicated; order preserved.
// - Simultaneous output pop and input push with both stages full: all three advance in the same cycle.
// STRUCTURE
// - Package honzales_pkg: mode constants MODE_ADD=2'b00, MODE_SATADD=2'b01, MODE_ACC=2'b10, MODE_SUB=2'b11;
//   default WIDTH/STEP_W localparams shared with the testbench wrapper.
// - Sub-module honzales_alu (combinational): inputs mode, d, step, acc -> result, ovf. Pipeline regs, handshake,
//   step and acc registers stay in honzales_stream.
// TESTING
// - ADD wrap: mode=00, step=1, in 0xFFFFF -> out 0x00000 ovf=1 at N+2; in 0x12345 -> 0x12346 ovf=0.
// - SATADD: io_step_we with step=5, then in 0xFFFFE -> out 0xFFFFF ovf=1; in 0x00010 -> 0x00015 ovf=0.
// - ACC: mode=10, in 3,4,5 back-to-back -> out 3,7,12 on consecutive cycles; mixed ADD word between leaves acc unchanged.
// - SUB: step=1, in 0x00000 -> out 0xFFFFF ovf=1.
// - Backpressure: io_out_ready=0 for 5 cycles, push 3 words -> in_ready drops after 2 accepted; release -> 3 results
//   in order, none lost, io_out_data stable while stalled.
// - Reset mid-op: 2 words in flight, reset=0 one cycle -> io_out_valid=0 next cycle, acc=0, step=1; no stale output.

Source files
------------

// File: rtl/honzales_pkg.sv
// Shared constants for the honzales_stream pipeline: op encodings and default widths.
package honzales_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 20;
    localparam int unsigned DEFAULT_STEP_W = 8;

    localparam logic [1:0] MODE_ADD    = 2'b00;
    localparam logic [1:0] MODE_SATADD = 2'b01;
    localparam logic [1:0] MODE_ACC    = 2'b10;
    localparam logic [1:0] MODE_SUB    = 2'b11;

endpackage

// File: rtl/honzales_alu.sv
// Combinational op unit: wrap add, saturating add, accumulate, wrap subtract with overflow flag.
module honzales_alu
    import honzales_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STEP_W = DEFAULT_STEP_W
) (
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  acc,
    output logic [WIDTH-1:0]  result,
    output logic              ovf
);

    logic [WIDTH-1:0] step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   acc_sum;

    always_comb begin
        step_ext              = '0;
        step_ext[STEP_W-1:0]  = step;
        sum                   = {1'b0, d} + {1'b0, step_ext};
        diff                  = {1'b0, d} - {1'b0, step_ext};
        acc_sum               = {1'b0, acc} + {1'b0, d};
    end

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unique case (mode)
            MODE_ADD: begin
                result = sum[WIDTH-1:0];
                ovf    = sum[WIDTH];
            end
            MODE_SATADD: begin
                result = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                ovf    = sum[WIDTH];
            end
            MODE_ACC: begin
                result = acc_sum[WIDTH-1:0];
                ovf    = acc_sum[WIDTH];
            end
            MODE_SUB: begin
                // Top bit of the extended difference is the borrow.
                result = diff[WIDTH-1:0];
                ovf    = diff[WIDTH];
            end
            default: begin
                result = '0;
                ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/honzales_stream.sv
// Two-stage valid/ready pipeline applying a runtime-selected arithmetic op to each streamed word.
module honzales_stream
    import honzales_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned STEP_W     = DEFAULT_STEP_W,
    parameter int unsigned RESET_STEP = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [WIDTH-1:0]  io_in_data,
    input  logic [1:0]        io_mode,
    input  logic              io_step_we,
    input  logic [STEP_W-1:0] io_step,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [WIDTH-1:0]  io_out_data,
    output logic              io_out_ovf
);

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_data_q, s1_data_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic [STEP_W-1:0] s1_step_q, s1_step_d;

    logic              s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  s2_data_q, s2_data_d;
    logic              s2_ovf_q, s2_ovf_d;

    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic              s1_moves;
    logic              accept;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_ovf;

    honzales_alu #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_alu (
        .mode   (s1_mode_q),
        .d      (s1_data_q),
        .step   (s1_step_q),
        .acc    (acc_q),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // Ready depends only on registered state, never on io_in_valid.
    always_comb begin
        s1_moves    = !s2_valid_q || io_out_ready;
        io_in_ready = !s1_valid_q || s1_moves;
        accept      = io_in_valid && io_in_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_step_d  = s1_step_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;
        acc_d      = acc_q;
        step_d     = step_q;

        if (io_step_we) begin
            step_d = io_step;
        end

        // Old step is captured when a write and an accept coincide.
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = io_in_data;
            s1_mode_d  = io_mode;
            s1_step_d  = step_q;
        end else if (s1_moves) begin
            s1_valid_d = 1'b0;
        end

        if (s1_moves) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = alu_result;
                s2_ovf_d  = alu_ovf;
                if (s1_mode_q == MODE_ACC) begin
                    acc_d = alu_result;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= MODE_ADD;
            s1_step_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
            acc_q      <= '0;
            step_q     <= STEP_W'(RESET_STEP);
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_step_q  <= s1_step_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
        end
    end

    always_comb begin
        io_out_valid = s2_valid_q;
        io_out_data  = s2_data_q;
        io_out_ovf   = s2_ovf_q;
    end

endmodule
